// File: rtl/data_ram_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_ram_if
// Description : Data-bus handshake between the CPU (master) and a data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, bus_error
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_ram_responder
// Description : Wait-stated word RAM answering the CPU data bus, one access
//               at a time, with a bus_error pulse for illegal accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    data_ram_if.slave   bus
);
    localparam int unsigned c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [32:0] c_SPAN  = 33'(c_DEPTH) << 2;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_readdata;
    logic        r_bus_error;
    logic [31:0] r_mem [c_DEPTH];

    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic                  w_legal;
    logic                  w_perform;
    logic [ADDR_WIDTH-1:0] w_word;

    // Unsigned subtraction wraps addresses below the base to huge offsets,
    // so a single compare covers both ends of the window.
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_SPAN);
    assign w_word     = w_offset[ADDR_WIDTH+1:2];
    assign w_legal    = w_in_range && !(r_rd && r_wr);
    assign w_perform  = (r_state == S_BUSY) && (r_cnt == 4'd0);

    always_comb begin
        bus.waitrequest = 1'b1;
        if (!reset) begin
            case (r_state)
                S_IDLE:  bus.waitrequest = bus.read | bus.write;
                S_DONE:  bus.waitrequest = 1'b0;
                default: bus.waitrequest = 1'b1;
            endcase
        end
    end

    assign bus.readdata  = r_readdata;
    assign bus.bus_error = r_bus_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_readdata  <= 32'd0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.read || bus.write) begin
                        r_addr  <= bus.address;
                        r_rd    <= bus.read;
                        r_wr    <= bus.write;
                        r_be    <= bus.byteenable;
                        r_wdata <= bus.writedata;
                        r_cnt   <= c_WAIT;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_rd) begin
                            r_readdata <= w_legal ? r_mem[w_word] : 32'd0;
                        end
                        r_bus_error <= !w_legal;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bus_error <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!reset && w_perform && r_wr && w_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_word][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_responder
// Description : Scoreboard bench for two responders (2 and 0 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_responder;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_if bus2 ();
    data_ram_if bus0 ();

    data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        string       nm;
        int          done_cyc;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic score(input exp_t e, input logic err, input logic [31:0] rd);
        chk({e.nm, " done cycle"}, 32'(cyc), 32'(e.done_cyc));
        chk({e.nm, " bus_error"}, {31'b0, err}, {31'b0, e.err});
        if (e.chk_rd) chk({e.nm, " readdata"}, rd, e.rd);
    endtask

    // A completion is waitrequest low while the master still holds a request.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0) begin
            if (bus2.waitrequest === 1'b0 && (bus2.read || bus2.write)) begin
                if (q2.size() == 0) chk("dut2 unexpected completion", 32'd1, 32'd0);
                else score(q2.pop_front(), bus2.bus_error, bus2.readdata);
            end else begin
                chk("dut2 bus_error outside DONE", {31'b0, bus2.bus_error}, 32'd0);
            end
            if (bus0.waitrequest === 1'b0 && (bus0.read || bus0.write)) begin
                if (q0.size() == 0) chk("dut0 unexpected completion", 32'd1, 32'd0);
                else score(q0.pop_front(), bus0.bus_error, bus0.readdata);
            end else begin
                chk("dut0 bus_error outside DONE", {31'b0, bus0.bus_error}, 32'd0);
            end
        end
    end

    task automatic drive(input bit sel, input logic [31:0] a, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (sel) begin
            bus0.address = a; bus0.read = rd; bus0.write = wr;
            bus0.byteenable = be; bus0.writedata = wd;
        end else begin
            bus2.address = a; bus2.read = rd; bus2.write = wr;
            bus2.byteenable = be; bus2.writedata = wd;
        end
    endtask

    task automatic txn(input bit sel, input string nm, input logic [31:0] a,
                       input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] wd, input logic exp_err, input logic chk_rd,
                       input logic [31:0] exp_rd, output int start);
        exp_t e;
        bit   done;
        @(posedge clk); #1;
        drive(sel, a, rd, wr, be, wd);
        start      = cyc;
        e.nm       = nm;
        e.done_cyc = start + (sel ? 0 : 2) + 2;
        e.err      = exp_err;
        e.chk_rd   = chk_rd;
        e.rd       = exp_rd;
        if (sel) q0.push_back(e);
        else     q2.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if ((sel ? bus0.waitrequest : bus2.waitrequest) === 1'b0) done = 1'b1;
        end
        if (!done) begin
            chk({nm, " timeout"}, 32'd1, 32'd0);
            @(posedge clk); #1;
            drive(sel, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    // Start a write, then assert reset in cycle abort_cyc of that transaction.
    task automatic reset_abort(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                               input int abort_cyc);
        @(posedge clk); #1;
        drive(sel, a, 1'b0, 1'b1, 4'hF, wd);
        repeat (abort_cyc) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(sel, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("abort waitrequest in reset",
            {31'b0, (sel ? bus0.waitrequest : bus2.waitrequest)}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort readdata cleared", (sel ? bus0.readdata : bus2.readdata), 32'd0);
        chk("abort back to idle", {31'b0, (sel ? bus0.waitrequest : bus2.waitrequest)}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, s1, s2, s3;
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset waitrequest", {31'b0, bus2.waitrequest}, 32'd1);
        chk("reset readdata", bus2.readdata, 32'd0);
        chk("reset bus_error", {31'b0, bus2.bus_error}, 32'd0);
        chk("reset waitrequest dut0", {31'b0, bus0.waitrequest}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle waitrequest", {31'b0, bus2.waitrequest}, 32'd0);

        txn(0, "wr 1010",            32'h1010, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0, s);
        txn(0, "rd 1010",            32'h1010, 1, 0, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF, s);
        txn(0, "wr lane1 hold rd",   32'h1010, 0, 1, 4'h2, 32'h0000AA00, 0, 1, 32'hDEADBEEF, s);
        txn(0, "rd after lane wr",   32'h1010, 1, 0, 4'h0, 32'h0,        0, 1, 32'hDEADAAEF, s);
        txn(0, "wr be0000",          32'h1010, 0, 1, 4'h0, 32'hFFFFFFFF, 0, 0, 32'h0, s);
        txn(0, "rd after noop wr",   32'h1010, 1, 0, 4'hF, 32'h0,        0, 1, 32'hDEADAAEF, s);
        txn(0, "wr 1000",            32'h1000, 0, 1, 4'hF, 32'h0BADF00D, 0, 0, 32'h0, s);
        txn(0, "wr 1020",            32'h1020, 0, 1, 4'hF, 32'h12345678, 0, 0, 32'h0, s);
        txn(0, "wr 1ffc",            32'h1FFC, 0, 1, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0, s);
        txn(0, "rd 1ffc",            32'h1FFD, 1, 0, 4'hF, 32'h0,        0, 1, 32'hCAFEF00D, s);
        txn(0, "rd 0ffc oor",        32'h0FFC, 1, 0, 4'hF, 32'h0,        1, 1, 32'h0, s);
        txn(0, "wr 2000 oor",        32'h2000, 0, 1, 4'hF, 32'h55555555, 1, 0, 32'h0, s);
        txn(0, "rd+wr 1000",         32'h1000, 1, 1, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0, s);
        txn(0, "rd 1000 unchanged",  32'h1000, 1, 0, 4'hF, 32'h0,        0, 1, 32'h0BADF00D, s);
        txn(0, "rd 1010 unchanged",  32'h1010, 1, 0, 4'hF, 32'h0,        0, 1, 32'hDEADAAEF, s);
        idle();

        reset_abort(0, 32'h1020, 32'hFFFF0000, 2);
        txn(0, "rd 1020 after abort", 32'h1020, 1, 0, 4'hF, 32'h0, 0, 1, 32'h12345678, s);
        idle();

        txn(1, "w0 wr 1004",         32'h1004, 0, 1, 4'hF, 32'hA5A5A5A5, 0, 0, 32'h0, s);
        idle();
        txn(1, "w0 rd 1004 a",       32'h1004, 1, 0, 4'hF, 32'h0, 0, 1, 32'hA5A5A5A5, s1);
        txn(1, "w0 rd 1004 b",       32'h1004, 1, 0, 4'hF, 32'h0, 0, 1, 32'hA5A5A5A5, s2);
        txn(1, "w0 rd 1004 c",       32'h1004, 1, 0, 4'hF, 32'h0, 0, 1, 32'hA5A5A5A5, s3);
        chk("w0 back-to-back spacing b", 32'(s2 - s1), 32'd3);
        chk("w0 back-to-back spacing c", 32'(s3 - s1), 32'd6);
        idle();

        reset_abort(1, 32'h1004, 32'h11111111, 1);
        txn(1, "w0 rd 1004 after abort", 32'h1004, 1, 0, 4'hF, 32'h0, 0, 1, 32'hA5A5A5A5, s);
        idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(q2.size() + q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
